// File: rtl/mem_access_initiator_if.sv
// Bus bundle between a memory access initiator and its environment
// (the requesting client on one side, the SRAM controller on the other).
//   req_*   : client request handshake and payload
//   resp_*  : one-cycle response back to the client
//   mem_*   : word-addressed strobe interface to the memory controller
// Modports:
//   master : the initiator block (drives req_ready, resp_*, mem strobes)
//   slave  : the environment (drives requests, acknowledges, read data)
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 16
`endif

interface mem_access_initiator_if #(
    parameter int MEM_ADDR_BITS = `MEM_ADDR_BITS
);
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_write;
    logic [MEM_ADDR_BITS+1:0]   req_addr;
    logic [1:0]                 req_size;
    logic                       req_unsigned;
    logic [31:0]                req_wdata;

    logic                       resp_valid;
    logic [31:0]                resp_rdata;
    logic                       resp_error;

    logic [MEM_ADDR_BITS-1:0]   mem_addr;
    logic                       mem_read_en;
    logic [3:0]                 mem_write_en;
    logic [31:0]                mem_write_data;
    logic [31:0]                mem_read_data;
    logic                       mem_read_ack;
    logic                       mem_write_ack;
    logic [MEM_ADDR_BITS-1:0]   mem_addr_ack;

    modport master (
        input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_error,
        output mem_addr, mem_read_en, mem_write_en, mem_write_data,
        input  mem_read_data, mem_read_ack, mem_write_ack, mem_addr_ack
    );

    modport slave (
        output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_error,
        input  mem_addr, mem_read_en, mem_write_en, mem_write_data,
        output mem_read_data, mem_read_ack, mem_write_ack, mem_addr_ack
    );
endinterface

// File: rtl/mem_access_initiator.sv
// Single-outstanding load/store initiator for the on-chip SRAM controller.
// Takes one byte/halfword/word request, issues a one-cycle word strobe with
// byte enables and lane-replicated store data, waits (bounded) for the
// matching acknowledge, and returns extended load data plus an error flag
// (misalignment, read address-echo mismatch, acknowledge timeout).
// Ports:
//   clk        : single clock
//   sync_reset : synchronous active-high reset
//   bus        : mem_access_initiator_if.master (request, response, memory)
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 16
`endif

module mem_access_initiator #(
    parameter int MEM_ADDR_BITS  = `MEM_ADDR_BITS,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                    clk,
    input  logic                    sync_reset,
    mem_access_initiator_if.master  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state;
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  lane_q;
    logic [7:0]  wait_cnt;
    logic        ack_hit;

    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'd0:    is_illegal = 1'b0;
            2'd1:    is_illegal = lane[0];
            2'd2:    is_illegal = (lane != 2'd0);
            default: is_illegal = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'd0:    byte_enables = 4'b0001 << lane;
            2'd1:    byte_enables = lane[1] ? 4'b1100 : 4'b0011;
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'd0:    replicate = {4{wdata[7:0]}};
            2'd1:    replicate = {2{wdata[15:0]}};
            default: replicate = wdata;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then extend per size/signedness.
    function automatic logic [31:0] extract(input logic [31:0] rdata, input logic [1:0] size,
                                            input logic [1:0] lane, input logic uns);
        logic [31:0] shifted;
        case (size)
            2'd0: begin
                shifted = rdata >> {lane, 3'b000};
                extract = {{24{shifted[7] & ~uns}}, shifted[7:0]};
            end
            2'd1: begin
                shifted = rdata >> {lane[1], 4'b0000};
                extract = {{16{shifted[15] & ~uns}}, shifted[15:0]};
            end
            default: begin
                shifted = rdata;
                extract = rdata;
            end
        endcase
    endfunction

    assign bus.req_ready = (state == IDLE) & ~sync_reset;

    // Only the acknowledge of the issued kind completes a transaction.
    assign ack_hit = write_q ? bus.mem_write_ack : bus.mem_read_ack;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state              <= IDLE;
            write_q            <= 1'b0;
            size_q             <= 2'd0;
            unsigned_q         <= 1'b0;
            lane_q             <= 2'd0;
            wait_cnt           <= 8'd0;
            bus.resp_valid     <= 1'b0;
            bus.resp_rdata     <= 32'd0;
            bus.resp_error     <= 1'b0;
            bus.mem_addr       <= '0;
            bus.mem_read_en    <= 1'b0;
            bus.mem_write_en   <= 4'b0000;
            bus.mem_write_data <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_q    <= bus.req_write;
                        size_q     <= bus.req_size;
                        unsigned_q <= bus.req_unsigned;
                        lane_q     <= bus.req_addr[1:0];
                        if (is_illegal(bus.req_size, bus.req_addr[1:0])) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_error <= 1'b1;
                            bus.resp_rdata <= 32'd0;
                            state          <= RESP;
                        end else begin
                            bus.mem_addr       <= bus.req_addr[MEM_ADDR_BITS+1:2];
                            bus.mem_write_data <= replicate(bus.req_size, bus.req_wdata);
                            if (bus.req_write)
                                bus.mem_write_en <= byte_enables(bus.req_size, bus.req_addr[1:0]);
                            else
                                bus.mem_read_en <= 1'b1;
                            state <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    bus.mem_read_en  <= 1'b0;
                    bus.mem_write_en <= 4'b0000;
                    wait_cnt         <= 8'd0;
                    state            <= WAIT;
                end

                // An acknowledge in the cycle the counter would hit the limit wins.
                WAIT: begin
                    if (ack_hit) begin
                        bus.resp_valid <= 1'b1;
                        state          <= RESP;
                        if (write_q) begin
                            bus.resp_error <= 1'b0;
                            bus.resp_rdata <= 32'd0;
                        end else if (bus.mem_addr_ack != bus.mem_addr) begin
                            bus.resp_error <= 1'b1;
                            bus.resp_rdata <= 32'd0;
                        end else begin
                            bus.resp_error <= 1'b0;
                            bus.resp_rdata <= extract(bus.mem_read_data, size_q, lane_q, unsigned_q);
                        end
                    end else if (wait_cnt + 8'd1 == TIMEOUT_LIMIT) begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_error <= 1'b1;
                        bus.resp_rdata <= 32'd0;
                        state          <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                RESP: begin
                    bus.resp_valid <= 1'b0;
                    state          <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_initiator.md
# mem_access_initiator

Initiator (requester) side of the single-word memory interface served by the on-chip SRAM memory controller. Accepts one byte, halfword or word load/store at a time from a client such as a load/store unit or debug loader. Converts it into a word-addressed strobe with byte enables and lane-replicated write data, then waits for the controller's read/write acknowledge. Returns extended load data plus an error flag for misalignment, address-echo mismatch or acknowledge timeout.

## Interface
- `MEM_ADDR_BITS`, default `` `MEM_ADDR_BITS``: word-address width of the memory interface.
- `TIMEOUT_CYCLES`, default 15: maximum cycles to wait for an acknowledge after the strobe cycle; range 1–255.

Clock and reset: one clock; reset is synchronous and active-high.

- `clk`  in  1  the single clock.
- `sync_reset`  in  1  synchronous active-high reset.
- `req_valid`  in  1  request present; accepted on a rising edge where `req_valid & req_ready`.
- `req_ready`  out  1  block idle and able to accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  MEM_ADDR_BITS+2  byte address.
- `req_size`  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- `req_unsigned`  in  1  loads only: zero-extend when 1, sign-extend when 0.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_error`  out  1  qualified by `resp_valid`.
- `mem_addr`  out  MEM_ADDR_BITS  word address, equal to `req_addr[MEM_ADDR_BITS+1:2]`.
- `mem_read_en`  out  1  one-cycle read strobe.
- `mem_write_en`  out  4  one-cycle byte-enable write strobe.
- `mem_write_data`  out  32  lane-replicated store data.
- `mem_read_data`  in  32  valid in the cycle `mem_read_ack` is high.
- `mem_read_ack`  in  1  read acknowledge.
- `mem_write_ack`  in  1  write acknowledge.
- `mem_addr_ack`  in  MEM_ADDR_BITS  word address echoed by the controller for reads.

## Operation
- **States:**
  - IDLE → ISSUE on acceptance of a legal request.
  - IDLE → RESP on acceptance of an illegal request; the error is set.
  - ISSUE → WAIT unconditionally.
  - WAIT → RESP on a matching acknowledge or on timeout.
  - RESP → IDLE unconditionally.
- `req_ready` = (state == IDLE) & ~`sync_reset`.
- **Illegal requests:** `req_size` = 3; halfword with `addr[0]` = 1; word with `addr[1:0]` ≠ 0. No strobe is issued; `resp_error` = 1.
- **Accept:** latch `req_write`, `req_size`, `req_unsigned` and `addr[1:0]`. Compute the following, then hold them stable until leaving WAIT:
  - `mem_addr`
  - byte enables:
    - byte → `1 << addr[1:0]`
    - halfword → `4'b0011` if `addr[1]` = 0, otherwise `4'b1100`
    - word → `4'b1111`
  - `mem_write_data`:
    - byte → `{4{wdata[7:0]}}`
    - halfword → `{2{wdata[15:0]}}`
    - word → `wdata`
- **ISSUE:** pulse `mem_write_en` (stores) or `mem_read_en` (loads) for exactly one cycle. The other strobe stays 0.
- **WAIT, store:** only `mem_write_ack` completes the transaction.
- **WAIT, load:** only `mem_read_ack` completes the transaction. Capture `mem_read_data`. Set the error if `mem_addr_ack` ≠ `mem_addr`.
- **Load extraction:** select the lane by `addr[1:0]` (byte) or by `addr[1]` (halfword), then sign- or zero-extend to 32 bits.
- **Timeout:** an 8-bit counter is cleared in ISSUE and increments each WAIT cycle without a matching acknowledge. Reaching `TIMEOUT_CYCLES` → RESP with `resp_error` = 1 and `resp_rdata` = 0.
- **Ignored inputs:** acknowledges outside WAIT (late or stray) and acknowledges of the wrong kind.
- **RESP:** `resp_valid` = 1 for one cycle. `resp_rdata` and `resp_error` are registered and hold their value until the next RESP.
- **Reset mid-operation:**
  - State → IDLE; all strobes deassert on the next edge.
  - No response is generated for the aborted request.
  - An acknowledge arriving after reset is ignored.

## Timing
- **Reset values:** state IDLE; `resp_valid`, `resp_error`, `resp_rdata`, `mem_read_en`, `mem_write_en`, `mem_write_data` and `mem_addr` are all 0. `req_ready` = 0 while `sync_reset` is high and 1 in the first cycle after it falls.
- All outputs except `req_ready` are registered.
- Cycle numbering: acceptance edge at the end of cycle 0.
  - Strobe: cycle 1.
  - Store: `mem_write_ack` in cycle 2, `resp_valid` in cycle 3, `req_ready` in cycle 4.
  - Load: `mem_read_ack` in cycle 3, `resp_valid` in cycle 4, `req_ready` in cycle 5.
  - General rule: `resp_valid` follows the acknowledge by one cycle.
- An acknowledge is honoured in cycles 2 … 1+`TIMEOUT_CYCLES`. With no acknowledge, `resp_valid` with error occurs in cycle 2+`TIMEOUT_CYCLES`.
- An acknowledge arriving in the same cycle the counter reaches the limit wins; the response is a success.
- Illegal request: `resp_valid` in cycle 1, no strobe, `req_ready` in cycle 2.
- Throughput is one outstanding request; `req_valid` while `req_ready` = 0 is not accepted.

## Test plan
- **Word store:** `addr` 0x10, data 0x11223344.
  - Cycle 1: `mem_addr` = 0x4, `mem_write_en` = 4'b1111, `mem_write_data` = 0x11223344.
  - Ack in cycle 2 → `resp_valid` in cycle 3 with `resp_error` = 0, `resp_rdata` = 0.
- **Halfword store:** `addr` 0x22, data 0x0000BEEF → `mem_addr` = 0x8, `mem_write_en` = 4'b1100, `mem_write_data` = 0xBEEFBEEF.
- **Byte load:** `addr` 0x13, controller returns 0x80AA5566 with `mem_addr_ack` = 0x4 in cycle 3.
  - Signed → `resp_rdata` = 0xFFFFFF80 in cycle 4.
  - Unsigned → `resp_rdata` = 0x00000080.
- **Illegal requests:** word load at `addr` 0x06, and a request with `req_size` = 3.
  - No strobe; `resp_valid` and `resp_error` = 1 in cycle 1.
- **Timeout and address echo:** `TIMEOUT_CYCLES` = 15.
  - Load with no acknowledge → error response in cycle 17, `resp_rdata` = 0. An acknowledge injected in cycle 18 is ignored.
  - Separately, a load acknowledged with `mem_addr_ack` ≠ `mem_addr` → `resp_error` = 1.
- **Reset mid-operation:** assert `sync_reset` in cycle 2 of a load.
  - Strobes stay 0; no `resp_valid`.
  - An acknowledge in cycle 3 is ignored.
  - `req_ready` = 1 in the cycle after reset falls; a following word store completes normally.
